// File: rtl/id_ex_stage.sv
// rtl/id_ex_stage.sv - ID/EX pipeline register with forwarding, valid/ready handshake and flush
// Optional feature macro: ID_EX_STALL_COUNT_EN (adds the stall_cycles saturating counter output)
module id_ex_stage #(
  parameter int XLEN  = 32,
  parameter int REGW  = 5,
  parameter int CTRLW = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [REGW-1:0]  in_rs1_addr,
  input  logic [REGW-1:0]  in_rs2_addr,
  input  logic [XLEN-1:0]  in_rs1_data,
  input  logic [XLEN-1:0]  in_rs2_data,
  input  logic [XLEN-1:0]  in_imm,
  input  logic             in_use_imm,
  input  logic [CTRLW-1:0] in_alu_ctrl,
  input  logic [REGW-1:0]  in_rd_addr,
  input  logic             in_reg_write,
  input  logic             flush,
  input  logic             exmem_reg_write,
  input  logic [REGW-1:0]  exmem_rd_addr,
  input  logic [XLEN-1:0]  exmem_result,
  input  logic             memwb_reg_write,
  input  logic [REGW-1:0]  memwb_rd_addr,
  input  logic [XLEN-1:0]  memwb_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  op1,
  output logic [XLEN-1:0]  op2,
  output logic [CTRLW-1:0] alu_ctrl,
  output logic [REGW-1:0]  out_rd_addr,
  output logic             out_reg_write
`ifdef ID_EX_STALL_COUNT_EN
  ,
  output logic [31:0]      stall_cycles
`endif
);

  logic             valid_q, valid_d;
  logic [REGW-1:0]  rs1_addr_q, rs1_addr_d;
  logic [REGW-1:0]  rs2_addr_q, rs2_addr_d;
  logic [XLEN-1:0]  rs1_data_q, rs1_data_d;
  logic [XLEN-1:0]  rs2_data_q, rs2_data_d;
  logic [XLEN-1:0]  imm_q, imm_d;
  logic             use_imm_q, use_imm_d;
  logic [CTRLW-1:0] alu_ctrl_q, alu_ctrl_d;
  logic [REGW-1:0]  rd_addr_q, rd_addr_d;
  logic             reg_write_q, reg_write_d;

  logic             capture;
  logic             retire;
  logic [XLEN-1:0]  fwd_rs1;
  logic [XLEN-1:0]  fwd_rs2;

  // Forwarding muxes: EX/MEM beats MEM/WB, x0 always reads the captured value
  always_comb begin
    fwd_rs1 = rs1_data_q;
    if (exmem_reg_write && (exmem_rd_addr == rs1_addr_q) && (rs1_addr_q != '0)) begin
      fwd_rs1 = exmem_result;
    end else if (memwb_reg_write && (memwb_rd_addr == rs1_addr_q) && (rs1_addr_q != '0)) begin
      fwd_rs1 = memwb_data;
    end
    fwd_rs2 = rs2_data_q;
    if (exmem_reg_write && (exmem_rd_addr == rs2_addr_q) && (rs2_addr_q != '0)) begin
      fwd_rs2 = exmem_result;
    end else if (memwb_reg_write && (memwb_rd_addr == rs2_addr_q) && (rs2_addr_q != '0)) begin
      fwd_rs2 = memwb_data;
    end
  end

  // Handshake and next-state: flush wins, then capture, then retire, else hold with refresh
  always_comb begin
    in_ready    = !flush && (!valid_q || out_ready);
    capture     = in_valid && in_ready;
    retire      = valid_q && out_ready;

    valid_d     = valid_q;
    rs1_addr_d  = rs1_addr_q;
    rs2_addr_d  = rs2_addr_q;
    rs1_data_d  = rs1_data_q;
    rs2_data_d  = rs2_data_q;
    imm_d       = imm_q;
    use_imm_d   = use_imm_q;
    alu_ctrl_d  = alu_ctrl_q;
    rd_addr_d   = rd_addr_q;
    reg_write_d = reg_write_q;

    if (flush) begin
      valid_d = 1'b0;
    end else if (capture) begin
      valid_d     = 1'b1;
      rs1_addr_d  = in_rs1_addr;
      rs2_addr_d  = in_rs2_addr;
      rs1_data_d  = in_rs1_data;
      rs2_data_d  = in_rs2_data;
      imm_d       = in_imm;
      use_imm_d   = in_use_imm;
      alu_ctrl_d  = in_alu_ctrl;
      rd_addr_d   = in_rd_addr;
      reg_write_d = in_reg_write;
    end else if (retire) begin
      valid_d = 1'b0;
    end else if (valid_q) begin
      // Latch forwarded data so it survives the producer leaving the pipeline
      rs1_data_d = fwd_rs1;
      rs2_data_d = fwd_rs2;
    end
  end

  // Pipeline register bank
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q     <= 1'b0;
      rs1_addr_q  <= '0;
      rs2_addr_q  <= '0;
      rs1_data_q  <= '0;
      rs2_data_q  <= '0;
      imm_q       <= '0;
      use_imm_q   <= 1'b0;
      alu_ctrl_q  <= '0;
      rd_addr_q   <= '0;
      reg_write_q <= 1'b0;
    end else begin
      valid_q     <= valid_d;
      rs1_addr_q  <= rs1_addr_d;
      rs2_addr_q  <= rs2_addr_d;
      rs1_data_q  <= rs1_data_d;
      rs2_data_q  <= rs2_data_d;
      imm_q       <= imm_d;
      use_imm_q   <= use_imm_d;
      alu_ctrl_q  <= alu_ctrl_d;
      rd_addr_q   <= rd_addr_d;
      reg_write_q <= reg_write_d;
    end
  end

  // Output drive: operands after forwarding, write enable qualified by valid
  always_comb begin
    out_valid     = valid_q;
    op1           = fwd_rs1;
    op2           = use_imm_q ? imm_q : fwd_rs2;
    alu_ctrl      = alu_ctrl_q;
    out_rd_addr   = rd_addr_q;
    out_reg_write = reg_write_q && valid_q;
  end

`ifdef ID_EX_STALL_COUNT_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;

  // Saturating count of cycles where a valid instruction is blocked downstream
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (valid_q && !out_ready && (stall_cnt_q != 32'hFFFF_FFFF)) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end
  end

  // Stall counter register; flush deliberately leaves it alone
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cycles = stall_cnt_q;
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// tb/tb_id_ex_stage.sv - directed scoreboard bench for id_ex_stage
module tb_id_ex_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  in_rs1_addr, in_rs2_addr;
  logic [31:0] in_rs1_data, in_rs2_data;
  logic [31:0] in_imm;
  logic        in_use_imm;
  logic [3:0]  in_alu_ctrl;
  logic [4:0]  in_rd_addr;
  logic        in_reg_write;
  logic        flush;
  logic        exmem_reg_write;
  logic [4:0]  exmem_rd_addr;
  logic [31:0] exmem_result;
  logic        memwb_reg_write;
  logic [4:0]  memwb_rd_addr;
  logic [31:0] memwb_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] op1, op2;
  logic [3:0]  alu_ctrl;
  logic [4:0]  out_rd_addr;
  logic        out_reg_write;
`ifdef ID_EX_STALL_COUNT_EN
  logic [31:0] stall_cycles;
`endif

  typedef struct packed {
    logic [31:0] op1;
    logic [31:0] op2;
    logic [3:0]  ctrl;
    logic [4:0]  rd;
    logic        rw;
  } exp_t;

  exp_t sb_q[$];
  int   n_assert = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  id_ex_stage dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .in_valid        (in_valid),
    .in_ready        (in_ready),
    .in_rs1_addr     (in_rs1_addr),
    .in_rs2_addr     (in_rs2_addr),
    .in_rs1_data     (in_rs1_data),
    .in_rs2_data     (in_rs2_data),
    .in_imm          (in_imm),
    .in_use_imm      (in_use_imm),
    .in_alu_ctrl     (in_alu_ctrl),
    .in_rd_addr      (in_rd_addr),
    .in_reg_write    (in_reg_write),
    .flush           (flush),
    .exmem_reg_write (exmem_reg_write),
    .exmem_rd_addr   (exmem_rd_addr),
    .exmem_result    (exmem_result),
    .memwb_reg_write (memwb_reg_write),
    .memwb_rd_addr   (memwb_rd_addr),
    .memwb_data      (memwb_data),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .op1             (op1),
    .op2             (op2),
    .alu_ctrl        (alu_ctrl),
    .out_rd_addr     (out_rd_addr),
    .out_reg_write   (out_reg_write)
`ifdef ID_EX_STALL_COUNT_EN
    ,
    .stall_cycles    (stall_cycles)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [4:0] rs1a, input logic [4:0] rs2a,
                       input logic [31:0] rs1d, input logic [31:0] rs2d,
                       input logic [31:0] imm, input logic use_imm,
                       input logic [3:0] ctrl, input logic [4:0] rd, input logic rw);
    in_valid     = 1'b1;
    in_rs1_addr  = rs1a;
    in_rs2_addr  = rs2a;
    in_rs1_data  = rs1d;
    in_rs2_data  = rs2d;
    in_imm       = imm;
    in_use_imm   = use_imm;
    in_alu_ctrl  = ctrl;
    in_rd_addr   = rd;
    in_reg_write = rw;
  endtask

  task automatic push(input logic [31:0] e1, input logic [31:0] e2,
                      input logic [3:0] ctrl, input logic [4:0] rd, input logic rw);
    exp_t e;
    e.op1 = e1; e.op2 = e2; e.ctrl = ctrl; e.rd = rd; e.rw = rw;
    sb_q.push_back(e);
  endtask

  task automatic set_idle();
    in_valid = 1'b0; in_rs1_addr = '0; in_rs2_addr = '0; in_rs1_data = '0; in_rs2_data = '0;
    in_imm = '0; in_use_imm = 1'b0; in_alu_ctrl = '0; in_rd_addr = '0; in_reg_write = 1'b0;
    flush = 1'b0; out_ready = 1'b1;
    exmem_reg_write = 1'b0; exmem_rd_addr = '0; exmem_result = '0;
    memwb_reg_write = 1'b0; memwb_rd_addr = '0; memwb_data = '0;
  endtask

  // Settle, pop/compare any retiring instruction, advance one clock
  task automatic step();
    exp_t e;
    #1;
    if (out_valid && out_ready) begin
      if (sb_q.size() == 0) begin
        chk("sb_underflow", sb_q.size(), 1);
      end else begin
        e = sb_q.pop_front();
        chk("sb_op1", op1, e.op1);
        chk("sb_op2", op2, e.op2);
        chk("sb_alu_ctrl", {28'd0, alu_ctrl}, {28'd0, e.ctrl});
        chk("sb_rd", {27'd0, out_rd_addr}, {27'd0, e.rd});
        chk("sb_reg_write", {31'd0, out_reg_write}, {31'd0, e.rw});
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    set_idle();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", {31'd0, out_valid}, 0);
    chk("rst_op1", op1, 0);
    chk("rst_op2", op2, 0);
    chk("rst_alu_ctrl", {28'd0, alu_ctrl}, 0);
    chk("rst_rd", {27'd0, out_rd_addr}, 0);
    chk("rst_reg_write", {31'd0, out_reg_write}, 0);
    chk("rst_in_ready", {31'd0, in_ready}, 1);
    rst_n = 1'b1;

    // ADD 10 + 20
    drive(5'd1, 5'd2, 32'd10, 32'd20, 32'd0, 1'b0, 4'b0010, 5'd4, 1'b1);
    push(32'd10, 32'd20, 4'b0010, 5'd4, 1'b1);
    #1;
    chk("add_in_ready", {31'd0, in_ready}, 1);
    step();
    in_valid = 1'b0;
    #1;
    chk("add_out_valid", {31'd0, out_valid}, 1);
    chk("add_op1", op1, 32'd10);
    chk("add_op2", op2, 32'd20);
    chk("add_ctrl", {28'd0, alu_ctrl}, 32'd2);
    chk("add_reg_write", {31'd0, out_reg_write}, 1);
    chk("add_sum", op1 + op2, 32'd30);
    step();
    chk("add_retired", {31'd0, out_valid}, 0);

    // Forwarding priority on a held instruction with rs1=3
    drive(5'd3, 5'd0, 32'd1, 32'd5, 32'd0, 1'b0, 4'b0110, 5'd7, 1'b1);
    step();
    in_valid = 1'b0;
    out_ready = 1'b0;
    exmem_reg_write = 1'b1; exmem_rd_addr = 5'd3; exmem_result = 32'd30;
    memwb_reg_write = 1'b1; memwb_rd_addr = 5'd3; memwb_data = 32'd99;
    #1;
    chk("fwd_exmem_prio", op1, 32'd30);
    chk("fwd_hold_in_ready", {31'd0, in_ready}, 0);
    exmem_reg_write = 1'b0;
    #1;
    chk("fwd_memwb", op1, 32'd99);
    memwb_reg_write = 1'b0;
    out_ready = 1'b1;
    #1;
    chk("fwd_none", op1, 32'd1);
    push(32'd1, 32'd5, 4'b0110, 5'd7, 1'b1);
    // Next instruction reads x0 while both producers target x0
    drive(5'd0, 5'd9, 32'd55, 32'd8, 32'd0, 1'b0, 4'b0111, 5'd0, 1'b0);
    exmem_reg_write = 1'b1; exmem_rd_addr = 5'd0; exmem_result = 32'd123;
    memwb_reg_write = 1'b1; memwb_rd_addr = 5'd0; memwb_data = 32'd99;
    push(32'd55, 32'd8, 4'b0111, 5'd0, 1'b0);
    step();
    in_valid = 1'b0;
    #1;
    chk("fwd_x0_op1", op1, 32'd55);
    chk("fwd_x0_reg_write", {31'd0, out_reg_write}, 0);
    step();
    exmem_reg_write = 1'b0; memwb_reg_write = 1'b0;

    // Stall with hold refresh from MEM/WB on rs2=5
    drive(5'd1, 5'd5, 32'd2, 32'd100, 32'd0, 1'b0, 4'b0010, 5'd6, 1'b1);
    push(32'd2, 32'd7, 4'b0010, 5'd6, 1'b1);
    step();
    drive(5'd8, 5'd9, 32'd11, 32'd12, 32'd0, 1'b0, 4'b0110, 5'd10, 1'b1);
    out_ready = 1'b0;
    memwb_reg_write = 1'b1; memwb_rd_addr = 5'd5; memwb_data = 32'd7;
    #1;
    chk("stall_op2_fwd", op2, 32'd7);
    chk("stall_in_ready0", {31'd0, in_ready}, 0);
    step();
    memwb_reg_write = 1'b0;
    #1;
    chk("stall_op2_kept", op2, 32'd7);
    chk("stall_in_ready1", {31'd0, in_ready}, 0);
    step();
    chk("stall_op2_kept2", op2, 32'd7);
    chk("stall_op1", op1, 32'd2);
    chk("stall_valid", {31'd0, out_valid}, 1);
    out_ready = 1'b1;
    push(32'd11, 32'd12, 4'b0110, 5'd10, 1'b1);
    #1;
    chk("release_in_ready", {31'd0, in_ready}, 1);
    step();
    in_valid = 1'b0;
    step();
    chk("stall_drained", {31'd0, out_valid}, 0);

    // Back-to-back, one immediate in the middle
    for (int i = 0; i < 3; i++) begin
      drive(5'(11 + i), 5'(14 + i), 32'(100 + i), 32'(200 + i), 32'hFFFF_FFFB,
            (i == 1), (i == 2) ? 4'b0111 : 4'b0010, 5'(20 + i), 1'b1);
      push(32'(100 + i), (i == 1) ? 32'hFFFF_FFFB : 32'(200 + i),
           (i == 2) ? 4'b0111 : 4'b0010, 5'(20 + i), 1'b1);
      #1;
      chk("b2b_in_ready", {31'd0, in_ready}, 1);
      if (i > 0) chk("b2b_valid", {31'd0, out_valid}, 1);
      step();
    end
    in_valid = 1'b0;
    #1;
    chk("b2b_valid_last", {31'd0, out_valid}, 1);
    step();
    chk("b2b_drained", {31'd0, out_valid}, 0);

    // Flush a held instruction while a new one is offered
    drive(5'd2, 5'd3, 32'd40, 32'd41, 32'd0, 1'b0, 4'b0010, 5'd12, 1'b1);
    step();
    out_ready = 1'b0;
    drive(5'd4, 5'd5, 32'd50, 32'd51, 32'd0, 1'b0, 4'b0110, 5'd13, 1'b1);
    flush = 1'b1;
    #1;
    chk("flush_in_ready", {31'd0, in_ready}, 0);
    chk("flush_pre_valid", {31'd0, out_valid}, 1);
    step();
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    #1;
    chk("flush_valid", {31'd0, out_valid}, 0);
    chk("flush_reg_write", {31'd0, out_reg_write}, 0);
    step();
    chk("flush_no_capture", {31'd0, out_valid}, 0);

    // Fresh reset, then a 4-cycle stall
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
`ifdef ID_EX_STALL_COUNT_EN
    chk("cnt_after_rst", stall_cycles, 0);
`endif
    drive(5'd6, 5'd7, 32'd3, 32'd4, 32'd0, 1'b0, 4'b0110, 5'd8, 1'b1);
    push(32'd3, 32'd4, 4'b0110, 5'd8, 1'b1);
    step();
    in_valid = 1'b0;
    out_ready = 1'b0;
    repeat (4) step();
    out_ready = 1'b1;
    #1;
`ifdef ID_EX_STALL_COUNT_EN
    chk("cnt_four", stall_cycles, 32'd4);
`endif
    chk("cnt_held_valid", {31'd0, out_valid}, 1);
    step();
`ifdef ID_EX_STALL_COUNT_EN
    chk("cnt_kept", stall_cycles, 32'd4);
`endif

    // Reset in the middle of a stall drops the held instruction
    drive(5'd9, 5'd10, 32'd70, 32'd71, 32'd0, 1'b0, 4'b0010, 5'd11, 1'b1);
    step();
    in_valid = 1'b0;
    out_ready = 1'b0;
    repeat (2) step();
`ifdef ID_EX_STALL_COUNT_EN
    chk("cnt_six", stall_cycles, 32'd6);
`endif
    rst_n = 1'b0;
    #1;
    chk("midrst_valid", {31'd0, out_valid}, 0);
    chk("midrst_op1", op1, 0);
    chk("midrst_reg_write", {31'd0, out_reg_write}, 0);
`ifdef ID_EX_STALL_COUNT_EN
    chk("midrst_cnt", stall_cycles, 0);
`endif
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    step();
    chk("sb_empty", sb_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
